// File: rtl/uart_reg_sequencer.sv
// ---------------------------------------------------------------------------
// uart_reg_sequencer
//
// Brings up a 16550-style UART after reset and then arbitrates single
// register accesses between a CPU request port and an optional transmit
// byte stream that feeds the THR.
//
// After reset the sequencer writes, one register per cycle:
//   LCR with DLAB set, DLL, DLM, LCR with DLAB clear, FCR
// and then raises init_done and starts serving requests.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata     CPU register request, held until cpu_ack
//   cpu_ack, cpu_rdata        one-cycle completion pulse, read data (held)
//   tx_valid, tx_data         byte stream towards THR (address 0)
//   tx_ready                  one-cycle pulse when a stream byte is taken
//   uart_cs/wr/addr/din       16550 register strobe, direction, address, data
//   uart_dout                 16550 read data, sampled during the access cycle
//   txrdy_n                   16550 TXRDYn, low when the THR/FIFO has room
//   init_done                 high from the first IDLE cycle until reset
//
// Build option
//   UART_SEQ_TX_STREAM_EN     when defined, the stream port takes part in
//                             round-robin arbitration; otherwise tx_ready is
//                             tied low and the CPU is the only requester.
// ---------------------------------------------------------------------------
module uart_reg_sequencer #(
    parameter logic [7:0] DIV_LSB = 8'h1B,
    parameter logic [7:0] DIV_MSB = 8'h00,
    parameter logic [7:0] LCR_VAL = 8'h03,
    parameter logic [7:0] FCR_VAL = 8'h07
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [2:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       uart_cs,
    output logic       uart_wr,
    output logic [2:0] uart_addr,
    output logic [7:0] uart_din,
    input  logic [7:0] uart_dout,
    input  logic       txrdy_n,
    output logic       init_done
);

    typedef enum logic [2:0] {
        INIT_LCR_DLAB,
        INIT_DLL,
        INIT_DLM,
        INIT_LCR,
        INIT_FCR,
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t     state;

    // Latched command for the single ACCESS cycle
    logic       cmd_we;
    logic       cmd_cpu;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_data;

    // Round-robin memory: 1 = stream was granted last, so the CPU wins the next tie
    logic       last_stream;

    logic       stream_elig;
    logic       grant_cpu;
    logic       grant_stream;

`ifdef UART_SEQ_TX_STREAM_EN
    // A stream byte is only worth granting when the UART can take it
    assign stream_elig = tx_valid & ~txrdy_n;
    // Valid/ready handshake completes in the grant cycle itself
    assign tx_ready    = grant_stream;
`else
    logic unused_stream;
    assign unused_stream = ^{tx_valid, tx_data, txrdy_n};
    assign stream_elig   = 1'b0;
    assign tx_ready      = 1'b0;
`endif

    always_comb begin
        grant_cpu    = 1'b0;
        grant_stream = 1'b0;
        if (state == IDLE) begin
            if (cpu_req && stream_elig) begin
                grant_cpu    = last_stream;
                grant_stream = ~last_stream;
            end else begin
                grant_cpu    = cpu_req;
                grant_stream = stream_elig;
            end
        end
    end

    // Register-port strobes are decoded straight from the state register so
    // each init write and each access occupies exactly its own state cycle.
    // Reset overrides the decode because the reset state is an init state.
    always_comb begin
        uart_cs   = 1'b0;
        uart_wr   = 1'b0;
        uart_addr = 3'd0;
        uart_din  = 8'h00;
        unique case (state)
            INIT_LCR_DLAB: begin
                uart_cs   = 1'b1;
                uart_wr   = 1'b1;
                uart_addr = 3'd3;
                uart_din  = {1'b1, LCR_VAL[6:0]};
            end
            INIT_DLL: begin
                uart_cs   = 1'b1;
                uart_wr   = 1'b1;
                uart_addr = 3'd0;
                uart_din  = DIV_LSB;
            end
            INIT_DLM: begin
                uart_cs   = 1'b1;
                uart_wr   = 1'b1;
                uart_addr = 3'd1;
                uart_din  = DIV_MSB;
            end
            INIT_LCR: begin
                uart_cs   = 1'b1;
                uart_wr   = 1'b1;
                uart_addr = 3'd3;
                uart_din  = {1'b0, LCR_VAL[6:0]};
            end
            INIT_FCR: begin
                uart_cs   = 1'b1;
                uart_wr   = 1'b1;
                uart_addr = 3'd2;
                uart_din  = FCR_VAL;
            end
            ACCESS: begin
                uart_cs   = 1'b1;
                uart_wr   = cmd_we;
                uart_addr = cmd_addr;
                uart_din  = cmd_data;
            end
            default: begin
            end
        endcase
        if (rst) begin
            uart_cs = 1'b0;
            uart_wr = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT_LCR_DLAB;
            init_done   <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= 8'h00;
            cmd_we      <= 1'b0;
            cmd_cpu     <= 1'b0;
            cmd_addr    <= 3'd0;
            cmd_data    <= 8'h00;
            last_stream <= 1'b1;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                INIT_LCR_DLAB: state <= INIT_DLL;
                INIT_DLL:      state <= INIT_DLM;
                INIT_DLM:      state <= INIT_LCR;
                INIT_LCR:      state <= INIT_FCR;
                INIT_FCR: begin
                    state     <= IDLE;
                    init_done <= 1'b1;
                end
                IDLE: begin
                    if (grant_cpu || grant_stream) begin
                        // Stream bytes always go to THR at address 0
                        cmd_cpu     <= grant_cpu;
                        cmd_we      <= grant_cpu ? cpu_we    : 1'b1;
                        cmd_addr    <= grant_cpu ? cpu_addr  : 3'd0;
                        cmd_data    <= grant_cpu ? cpu_wdata : tx_data;
                        last_stream <= grant_stream;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Read data is captured while cs is asserted so it is
                    // already valid when the ack pulse appears in RESP.
                    if (cmd_cpu) begin
                        cpu_ack <= 1'b1;
                        if (!cmd_we) begin
                            cpu_rdata <= uart_dout;
                        end
                    end
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= INIT_LCR_DLAB;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_sequencer.sv
module tb_uart_reg_sequencer;

`ifdef UART_SEQ_TX_STREAM_EN
    localparam bit STREAM = 1'b1;
`else
    localparam bit STREAM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req;
    logic       cpu_we;
    logic [2:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       uart_cs;
    logic       uart_wr;
    logic [2:0] uart_addr;
    logic [7:0] uart_din;
    logic [7:0] uart_dout;
    logic       txrdy_n;
    logic       init_done;

    uart_reg_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .uart_cs   (uart_cs),
        .uart_wr   (uart_wr),
        .uart_addr (uart_addr),
        .uart_din  (uart_din),
        .uart_dout (uart_dout),
        .txrdy_n   (txrdy_n),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_ack  = 0;
    int n_txr  = 0;

    // Expected init writes for the default parameters
    logic [2:0] init_a [5] = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2};
    logic [7:0] init_d [5] = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07};

    // Reference model: init_step counts completed init writes (5 = done),
    // busy counts remaining cycles of a transaction (2 = strobe, 1 = response)
    int         m_init;
    int         m_busy;
    bit         m_last_str;
    bit         m_cpu;
    bit         m_we;
    logic [2:0] m_addr;
    logic [7:0] m_data;
    logic [7:0] m_rdata;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model at the edge,
    // then return shortly after the edge so the caller can drive new inputs.
    task automatic cycle();
        bit g_cpu, g_str, elig, e_ack;
        g_cpu = 1'b0;
        g_str = 1'b0;
        e_ack = 1'b0;
        @(negedge clk);
        if (cpu_ack === 1'b1) n_ack++;
        if (tx_ready === 1'b1) n_txr++;
        if (rst) begin
            m_init = 0; m_busy = 0; m_last_str = 1'b1; m_rdata = 8'h00;
            chk("rst_cs", {7'd0, uart_cs}, 8'd0);
            chk("rst_wr", {7'd0, uart_wr}, 8'd0);
            chk("rst_ack", {7'd0, cpu_ack}, 8'd0);
            chk("rst_txready", {7'd0, tx_ready}, 8'd0);
            chk("rst_init_done", {7'd0, init_done}, 8'd0);
            chk("rst_rdata", cpu_rdata, 8'h00);
        end else begin
            if (m_init < 5) begin
                chk("init_cs", {7'd0, uart_cs}, 8'd1);
                chk("init_wr", {7'd0, uart_wr}, 8'd1);
                chk("init_addr", {5'd0, uart_addr}, {5'd0, init_a[m_init]});
                chk("init_din", uart_din, init_d[m_init]);
            end else if (m_busy == 0) begin
                elig = STREAM && tx_valid && !txrdy_n;
                if (cpu_req && elig) begin
                    g_cpu = m_last_str;
                    g_str = !m_last_str;
                end else begin
                    g_cpu = cpu_req;
                    g_str = elig;
                end
                chk("idle_cs", {7'd0, uart_cs}, 8'd0);
            end else if (m_busy == 2) begin
                chk("acc_cs", {7'd0, uart_cs}, 8'd1);
                chk("acc_wr", {7'd0, uart_wr}, {7'd0, m_we});
                chk("acc_addr", {5'd0, uart_addr}, {5'd0, m_addr});
                chk("acc_din", uart_din, m_data);
            end else begin
                chk("resp_cs", {7'd0, uart_cs}, 8'd0);
                e_ack = m_cpu;
            end
            chk("cpu_ack", {7'd0, cpu_ack}, {7'd0, e_ack});
            chk("tx_ready", {7'd0, tx_ready}, {7'd0, g_str});
            chk("init_done", {7'd0, init_done}, {7'd0, (m_init == 5)});
            chk("cpu_rdata", cpu_rdata, m_rdata);
        end
        @(posedge clk);
        if (!rst) begin
            if (m_init < 5) begin
                m_init++;
            end else if (m_busy == 0) begin
                if (g_cpu || g_str) begin
                    m_cpu      = g_cpu;
                    m_we       = g_cpu ? cpu_we : 1'b1;
                    m_addr     = g_cpu ? cpu_addr : 3'd0;
                    m_data     = g_cpu ? cpu_wdata : tx_data;
                    m_last_str = g_str;
                    m_busy     = 2;
                end
            end else if (m_busy == 2) begin
                if (m_cpu && !m_we) m_rdata = uart_dout;
                m_busy = 1;
            end else begin
                m_busy = 0;
            end
        end
        #1;
    endtask

    initial begin
        int ack0, txr0, rst_left;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 3'd0; cpu_wdata = 8'h00;
        tx_valid = 1'b0; tx_data = 8'h00; txrdy_n = 1'b1; uart_dout = 8'h00;
        m_init = 0; m_busy = 0; m_last_str = 1'b1; m_rdata = 8'h00;
        m_cpu = 1'b0; m_we = 1'b0; m_addr = 3'd0; m_data = 8'h00;

        // Reset values, then the five init writes and first IDLE cycle
        repeat (2) cycle();
        rst = 1'b0;
        repeat (6) cycle();

        // CPU read of LSR, request dropped right after the grant
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd5; uart_dout = 8'h60;
        cycle();
        cpu_req = 1'b0;
        repeat (2) cycle();
        chk("lsr_read_data", cpu_rdata, 8'h60);
        repeat (2) cycle();

        // CPU and stream contending continuously
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 3'd7; cpu_wdata = 8'h5A;
        tx_valid = 1'b1; tx_data = 8'h41; txrdy_n = 1'b0;
        repeat (24) cycle();
        cpu_req = 1'b0;
        repeat (3) cycle();

        // Stream blocked by TXRDYn, then released
        tx_valid = 1'b1; txrdy_n = 1'b1;
        ack0 = n_ack; txr0 = n_txr;
        repeat (20) cycle();
        chk("blocked_txready", n_txr[7:0], txr0[7:0]);
        txrdy_n = 1'b0;
        repeat (4) cycle();
        tx_valid = 1'b0;
        repeat (3) cycle();

        // Reset during a CPU access: no ack, full init again
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd2; uart_dout = 8'hC1;
        cycle();
        ack0 = n_ack;
        rst = 1'b1;
        cpu_req = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (6) cycle();
        chk("abort_no_ack", n_ack[7:0], ack0[7:0]);

        // Randomised traffic with occasional resets
        rst_left = 0;
        for (int i = 0; i < 2000; i++) begin
            if (rst_left > 0) begin
                rst_left--;
                rst = (rst_left > 0);
            end else if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
                rst_left = $urandom_range(1, 3);
            end
            if (m_busy == 1 && m_cpu) begin
                cpu_req = 1'b0;
            end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 3'($urandom_range(0, 7));
                cpu_wdata = 8'($urandom);
            end
            tx_valid  = 1'($urandom_range(0, 1));
            tx_data   = 8'($urandom);
            txrdy_n   = ($urandom_range(0, 3) == 0);
            uart_dout = 8'($urandom);
            cycle();
        end
        rst = 1'b0;
        cpu_req = 1'b0;
        repeat (8) cycle();

        chk("cpu_acks_seen", {7'd0, (n_ack > 10)}, 8'd1);
        chk("stream_grants_seen", {7'd0, (n_txr > 10)}, {7'd0, STREAM});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_reg_sequencer.md
UART_REG_SEQUENCER -- requirements
Module: uart_reg_sequencer

Interface
REQ-001 SHALL have parameter DIV_LSB, default 8'h1B, divisor latch low byte programmed at init.
REQ-002 SHALL have parameter DIV_MSB, default 8'h00, divisor latch high byte programmed at init.
REQ-003 SHALL have parameter LCR_VAL, default 8'h03, line control value, bit 7 ignored (8N1 default).
REQ-004 SHALL have parameter FCR_VAL, default 8'h07, FIFO control value written last in init.
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in 3, cpu_wdata in 8  CPU register request, held until ack.
REQ-008 SHALL have ports cpu_ack out 1 (one-cycle pulse), cpu_rdata out 8  CPU completion and read data.
REQ-009 SHALL have ports tx_valid in 1, tx_data in 8, tx_ready out 1  byte stream into THR, valid/ready.
REQ-010 SHALL have ports uart_cs out 1, uart_wr out 1, uart_addr out 3, uart_din out 8, uart_dout in 8  16550 register port.
REQ-011 SHALL have port txrdy_n  in  1  16550 TXRDYn; low = THR/FIFO accepts a byte.
REQ-012 SHALL have port init_done  out  1  high once init sequence completes.

Function
REQ-013 SHALL run FSM states INIT_LCR_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR, IDLE, ACCESS, RESP.
REQ-014 Init states SHALL each last one cycle with uart_cs=uart_wr=1: addr 3 data {1,LCR_VAL[6:0]}; addr 0 DIV_LSB; addr 1 DIV_MSB; addr 3 {0,LCR_VAL[6:0]}; addr 2 FCR_VAL; then IDLE.
REQ-015 init_done SHALL go high in the first IDLE cycle and stay high until reset.
REQ-016 In IDLE, a grant SHALL latch addr/we/data into a command register and move to ACCESS next cycle.
REQ-017 ACCESS SHALL drive uart_cs=1 for exactly one cycle with latched uart_wr/uart_addr/uart_din; uart_cs=0 in every other non-init state.
REQ-018 RESP SHALL last one cycle; for a CPU grant it pulses cpu_ack and, on reads, loads cpu_rdata from uart_dout; then IDLE.
REQ-019 CPU latency: cpu_req seen in IDLE at cycle N (and granted) -> uart_cs at N+1 -> cpu_ack at N+2; back-to-back grant earliest at N+3.
REQ-020 Stream grant SHALL write addr 0 with tx_data; tx_ready pulses one cycle in the IDLE grant cycle; no cpu_ack.
REQ-021 Stream SHALL be eligible only when tx_valid=1 and txrdy_n=0; otherwise CPU wins uncontested.
REQ-022 When both eligible, grant SHALL round-robin on a last-grant bit (reset value = stream, so CPU wins first tie).
REQ-023 Requests SHALL be ignored (no ack, no ready) before init_done.
REQ-024 cpu_req dropped after grant SHALL NOT cancel the access; cpu_rdata SHALL hold its value between reads.
REQ-025 CPU writes (including LCR with DLAB=1) SHALL pass through unmodified; no register shadowing.

Reset
REQ-026 rst SHALL asynchronously force state INIT_LCR_DLAB, init_done=0, cpu_ack=0, tx_ready=0, cpu_rdata=8'h00, command register 0, last-grant=stream.
REQ-027 Reset during ACCESS/RESP SHALL abort the access without ack; init SHALL restart from INIT_LCR_DLAB after rst falls.
REQ-028 While rst=1, uart_cs and uart_wr SHALL be 0.

Configuration
REQ-029 With UART_SEQ_TX_STREAM_EN defined, the stream port and round-robin SHALL function as above.
REQ-030 Without UART_SEQ_TX_STREAM_EN, tx_ready SHALL be constant 0, tx_valid/tx_data/txrdy_n ignored, CPU sole requester.

Verification
REQ-031 Defaults, release rst -> five cs pulses: (3,8'h83),(0,8'h1B),(1,8'h00),(3,8'h03),(2,8'h07); init_done high on 6th cycle.
REQ-032 After init, CPU read addr 5, uart_dout=8'h60 -> cs with wr=0 one cycle later, cpu_ack and cpu_rdata=8'h60 next cycle.
REQ-033 cpu_req and tx_valid (tx_data=8'h41, txrdy_n=0) held continuously -> grants alternate CPU, stream, CPU, ...; each stream write addr 0 data 8'h41.
REQ-034 tx_valid=1, txrdy_n=1 for 20 cycles -> no tx_ready, no cs; txrdy_n=0 -> write issued within 2 cycles.
REQ-035 rst asserted during CPU ACCESS -> no cpu_ack, outputs at reset values, full init sequence repeats.
REQ-036 Build without UART_SEQ_TX_STREAM_EN, tx_valid=1, txrdy_n=0 -> tx_ready never high, CPU accesses unaffected.
